// File: rtl/typepkg.sv
// Shared ROM map constants and response bundle for the ROM arbiter.
// Imported by rom_arb_slot and rom_arbiter.
package typepkg;

    localparam int          ROM_BITS      = 12;
    localparam logic [31:0] ROM_BASE_ADDR = 32'h0000_0000;
    localparam logic [31:0] ROM_END_ADDR  = 32'h0000_1000;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rom_rsp_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Word-aligned and inside [ROM_BASE_ADDR, ROM_END_ADDR).
    // Offset form keeps the lower bound meaningful for any base.
    function automatic logic addr_ok(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - ROM_BASE_ADDR;
        return (off < (ROM_END_ADDR - ROM_BASE_ADDR)) &&
               (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/rom_arb_slot.sv
// Per-port response register with EMPTY/FULL handshake FSM.
// Loads a new response on accept; drains on rsp_valid & rsp_ready.
module rom_arb_slot
    import typepkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     accept,
    input  rom_rsp_t load,
    input  logic     rsp_ready,
    output logic     rsp_valid,
    output rom_rsp_t rsp,
    output logic     free
);

    slot_state_t state_q;
    slot_state_t state_d;

    assign rsp_valid = (state_q == SLOT_FULL);
    assign free      = (state_q == SLOT_EMPTY) | rsp_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: fill on accept, empty on handshake without refill.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SLOT_EMPTY: if (accept) state_d = SLOT_FULL;
            SLOT_FULL: begin
                if (accept)         state_d = SLOT_FULL;
                else if (rsp_ready) state_d = SLOT_EMPTY;
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    // Response payload only changes on accept so it holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp <= '0;
        end else if (accept) begin
            rsp <= load;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Two-port (IF/LS) arbiter for the single-port ROM with 1-cycle responses.
// Optional ROM_ARB_STATS_EN adds conflict_cnt and err_cnt outputs.
module rom_arbiter
    import typepkg::*;
#(
    parameter int MAX_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [31:0]         if_req_addr,
    output logic                if_rsp_valid,
    input  logic                if_rsp_ready,
    output logic [31:0]         if_rsp_data,
    output logic                if_rsp_err,
    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic [31:0]         ls_req_addr,
    output logic                ls_rsp_valid,
    input  logic                ls_rsp_ready,
    output logic [31:0]         ls_rsp_data,
    output logic                ls_rsp_err,
`ifdef ROM_ARB_STATS_EN
    output logic [31:0]         conflict_cnt,
    output logic [31:0]         err_cnt,
`endif
    output logic [ROM_BITS-3:0] rom_addr,
    input  logic [31:0]         rom_data
);

    localparam logic [3:0] MAX_S = 4'(MAX_STREAK);

    logic                if_free;
    logic                ls_free;
    logic                elig_if;
    logic                elig_ls;
    logic                if_gnt;
    logic                ls_gnt;
    logic                any_gnt;
    logic [31:0]         sel_addr;
    logic                sel_ok;
    logic [3:0]          streak_q;
    logic [3:0]          streak_d;
    logic [ROM_BITS-3:0] addr_q;
    rom_rsp_t            load;
    rom_rsp_t            if_rsp;
    rom_rsp_t            ls_rsp;

    assign elig_if = if_req_valid & if_free;
    assign elig_ls = ls_req_valid & ls_free;

    // Grant: LS preferred until it has starved a pending IF MAX_STREAK times.
    always_comb begin
        if_gnt = elig_if & (~elig_ls | (streak_q == MAX_S));
        ls_gnt = elig_ls & ~if_gnt;
    end

    assign if_req_ready = if_gnt;
    assign ls_req_ready = ls_gnt;
    assign any_gnt      = if_gnt | ls_gnt;
    assign sel_addr     = if_gnt ? if_req_addr : ls_req_addr;
    assign sel_ok       = addr_ok(sel_addr);

    // Streak counter next value: count LS wins over an eligible IF.
    always_comb begin
        streak_d = streak_q;
        if (if_gnt || !if_req_valid) begin
            streak_d = '0;
        end else if (ls_gnt && elig_if && streak_q != MAX_S) begin
            streak_d = streak_q + 4'd1;
        end
    end

    // Streak register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    assign rom_addr = any_gnt ? sel_addr[ROM_BITS-1:2] : addr_q;

    // Remember the last granted word address so rom_addr holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else if (any_gnt) begin
            addr_q <= sel_addr[ROM_BITS-1:2];
        end
    end

    // Response word for whichever port is granted this cycle.
    always_comb begin
        load.data = sel_ok ? rom_data : 32'h0;
        load.err  = ~sel_ok;
    end

    rom_arb_slot u_if_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .accept    (if_gnt),
        .load      (load),
        .rsp_ready (if_rsp_ready),
        .rsp_valid (if_rsp_valid),
        .rsp       (if_rsp),
        .free      (if_free)
    );

    rom_arb_slot u_ls_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .accept    (ls_gnt),
        .load      (load),
        .rsp_ready (ls_rsp_ready),
        .rsp_valid (ls_rsp_valid),
        .rsp       (ls_rsp),
        .free      (ls_free)
    );

    assign if_rsp_data = if_rsp.data;
    assign if_rsp_err  = if_rsp.err;
    assign ls_rsp_data = ls_rsp.data;
    assign ls_rsp_err  = ls_rsp.err;

`ifdef ROM_ARB_STATS_EN
    // Contention and error event counters, free-running with wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
            err_cnt      <= '0;
        end else begin
            if (if_req_valid && ls_req_valid) begin
                conflict_cnt <= conflict_cnt + 32'd1;
            end
            if (any_gnt && !sel_ok) begin
                err_cnt <= err_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
